// File: rtl/bin2bcd_seq_if.sv
// Handshake/data bundle between a binary producer and the bin2bcd_seq converter.
// The master drives start/bin_in; the slave (converter) returns status and the BCD word.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;
  logic [DIGITS-1:0]     blank_mask;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf, blank_mask
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf, blank_mask
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with input saturation and overflow flag.
// Define BLANK_LZ_EN to produce leading-zero blank flags; otherwise blank_mask is tied low.
module bin2bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4,
  parameter int SAT_MAX = 9999
) (
  input  logic          clock_100Mhz,
  input  logic          reset,
  bin2bcd_seq_if.slave  bus
);
  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] SAT_VAL = BIN_W'(SAT_MAX);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_reg;
  logic [BIN_W-1:0]        operand_reg;
  logic [SCR_W-1:0]        scratch_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    ovf_pending_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic [SCR_W-1:0]        bcd_reg;
  logic                    ovf_reg;
  logic [SCR_W-1:0]        adj_next;
  logic [SCR_W+BIN_W-1:0]  shift_next;

  // Add-3 correction on every nibble before it is doubled by the shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj_next[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                                   scratch_reg[4*gi +: 4] + 4'd3 :
                                   scratch_reg[4*gi +: 4];
    end
  endgenerate

  assign shift_next = {adj_next, operand_reg} << 1;

`ifdef BLANK_LZ_EN
  logic [DIGITS:0]   lz_chain;
  logic [DIGITS-1:0] blank_reg;

  // lz_chain[i] is high when digit i and all digits above it are zero; units never blank.
  assign lz_chain[DIGITS] = 1'b1;
  assign lz_chain[0]      = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_lz
      assign lz_chain[gi] = lz_chain[gi+1] & (scratch_reg[4*gi +: 4] == 4'd0);
    end
  endgenerate

  assign bus.blank_mask = blank_reg;
`else
  assign bus.blank_mask = '0;
`endif

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_reg       <= IDLE;
      operand_reg     <= '0;
      scratch_reg     <= '0;
      cnt_reg         <= '0;
      ovf_pending_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      bcd_reg         <= '0;
      ovf_reg         <= 1'b0;
`ifdef BLANK_LZ_EN
      blank_reg       <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            operand_reg     <= (bus.bin_in > SAT_VAL) ? SAT_VAL : bus.bin_in;
            ovf_pending_reg <= (bus.bin_in > SAT_VAL);
            scratch_reg     <= '0;
            cnt_reg         <= '0;
            busy_reg        <= 1'b1;
            state_reg       <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch_reg, operand_reg} <= shift_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(BIN_W - 1))
            state_reg <= DONE;
        end
        DONE: begin
          bcd_reg   <= scratch_reg;
          ovf_reg   <= ovf_pending_reg;
`ifdef BLANK_LZ_EN
          blank_reg <= lz_chain[DIGITS-1:0];
`endif
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.bcd_out = bcd_reg;
  assign bus.ovf     = ovf_reg;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed handshake cases plus randomized conversions
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;
  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int SAT_MAX = 9999;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .SAT_MAX(SAT_MAX)) dut (
    .clock_100Mhz (clk),
    .reset        (rst),
    .bus          (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Decimal digits of the saturated value, units digit in the low nibble.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
    int r;
    logic [4*DIGITS-1:0] res;
    r   = (v > SAT_MAX) ? SAT_MAX : v;
    res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  function automatic logic [DIGITS-1:0] ref_blank(input int v);
    logic [DIGITS-1:0] m;
    int r;
    r = (v > SAT_MAX) ? SAT_MAX : v;
    m = '0;
`ifdef BLANK_LZ_EN
    for (int i = 1; i < DIGITS; i++)
      if (r < 10**i) m[i] = 1'b1;
`endif
    return m;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues start with v, optionally pokes a second start mid-conversion, and checks the result.
  task automatic run_conv(input int v, input int poke_at, input int poke_val);
    int lat;
    int busy_n;
    bus.bin_in = BIN_W'(v);
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.bin_in = BIN_W'($urandom);
    lat    = 0;
    busy_n = bus.busy ? 1 : 0;
    while (!bus.done && lat < 40) begin
      if (lat == poke_at) begin
        bus.start  = 1'b1;
        bus.bin_in = BIN_W'(poke_val);
      end
      tick();
      bus.start = 1'b0;
      lat++;
      if (!bus.done && bus.busy) busy_n++;
    end
    check("latency", lat, BIN_W + 1);
    check("busy_cycles", busy_n, BIN_W + 1);
    check("busy_at_done", bus.busy, 1'b0);
    check("bcd_out", bus.bcd_out, ref_bcd(v));
    check("ovf", bus.ovf, (v > SAT_MAX) ? 1 : 0);
    check("blank_mask", bus.blank_mask, ref_blank(v));
    $display("[TB] conv in=%0d bcd=%h ovf=%0d blank=%b lat=%0d",
             v, bus.bcd_out, bus.ovf, bus.blank_mask, lat);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_bcd", bus.bcd_out, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_blank", bus.blank_mask, 0);

    run_conv(1234, -1, 0);
    tick();
    check("done_one_cycle", bus.done, 0);
    repeat (5) tick();
    check("hold_bcd", bus.bcd_out, 16'h1234);

    run_conv(0, -1, 0);
    tick();
    run_conv(9999, -1, 0);
    run_conv(10000, -1, 0);
    run_conv(12000, -1, 0);
    run_conv((1 << BIN_W) - 1, -1, 0);
    tick();

    // start while busy must be ignored and not queued
    run_conv(9, 5, 42);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) dn++;
    end
    check("no_queued_done", dn, 0);
    check("hold_after_ignore", bus.bcd_out, 16'h0009);

    // back-to-back: second start issued in the done cycle
    run_conv(100, -1, 0);
    run_conv(507, -1, 0);
    tick();

    // reset aborts a conversion in progress
    run_conv(1234, -1, 0);
    tick();
    bus.bin_in = BIN_W'(8765);
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_bcd", bus.bcd_out, 0);
    check("abort_ovf", bus.ovf, 0);
    check("abort_blank", bus.blank_mask, 0);
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.done || bus.busy) dn++;
    end
    check("abort_no_done", dn, 0);

    // back-to-back streams over both ends of the range, then random values
    for (int v = 0; v < 100; v++) run_conv(v, -1, 0);
    for (int v = SAT_MAX - 99; v <= SAT_MAX; v++) run_conv(v, -1, 0);
    for (int n = 0; n < 300; n++) run_conv(int'($urandom_range(0, SAT_MAX)), -1, 0);
    for (int n = 0; n < 200; n++) run_conv(int'($urandom_range(0, (1 << BIN_W) - 1)), -1, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
